// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: ramps duty_out from its current value to a target.
// Each update moves duty_out by a programmable step. Updates happen once every
// (div+1) clocks. Every new configuration is latched on cfg_valid.
// Optional feature macro: PWM_FADE_BREATHE_EN adds the cfg_breathe input.
// With breathe latched, the ramp bounces between the target and 0 until it is
// stopped by abort, reset, or a non-breathe cfg_valid.
module pwm_fade_controller #(
  parameter int                 DUTY_W     = 8,
  parameter int                 DIV_W      = 8,
  parameter logic [DUTY_W-1:0]  RESET_DUTY = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [3:0]        cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef PWM_FADE_BREATHE_EN
  input  logic              cfg_breathe,
`endif
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t            state;
  logic [DIV_W-1:0]  presc;
  logic [DUTY_W-1:0] tgt;
  logic [3:0]        stp;
  logic [DIV_W-1:0]  div;

  // Current ramp endpoint. In breathe mode it alternates between tgt and 0.
  // In normal mode it is simply the latched target.
  logic [DUTY_W-1:0] goal;
  // True when the running ramp loops instead of finishing.
  logic              loop_on;
  // True when a new configuration requests a looping ramp.
  logic              cfg_loop;

`ifdef PWM_FADE_BREATHE_EN
  logic              breathe;
  logic [DUTY_W-1:0] dest;

  assign goal     = dest;
  assign loop_on  = breathe && (tgt != '0);
  assign cfg_loop = cfg_breathe && (cfg_target != '0);
`else
  assign goal     = tgt;
  assign loop_on  = 1'b0;
  assign cfg_loop = 1'b0;
`endif

  logic [3:0]        cfg_step_eff;
  logic [DUTY_W-1:0] stp_ext;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] dn_diff;
  logic              up_hit;
  logic              dn_hit;
  logic              tick;

  // Compute the step size, the arithmetic for both directions, and the prescaler tick.
  // The up sum is one bit wider so that it can never wrap past full scale.
  always_comb begin
    cfg_step_eff = (cfg_step == 4'd0) ? 4'd1 : cfg_step;
    stp_ext      = {{(DUTY_W-4){1'b0}}, stp};
    up_sum       = {1'b0, duty_out} + {1'b0, stp_ext};
    up_hit       = up_sum >= {1'b0, goal};
    dn_diff      = duty_out - goal;
    dn_hit       = dn_diff <= stp_ext;
    tick         = (presc == div);
  end

  // Ramp sequencer. The priority order is abort, then cfg_valid, then the prescaler tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_out <= RESET_DUTY;
      busy     <= 1'b0;
      done     <= 1'b0;
      presc    <= '0;
      tgt      <= '0;
      stp      <= '0;
      div      <= '0;
`ifdef PWM_FADE_BREATHE_EN
      breathe  <= 1'b0;
      dest     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        if (state != IDLE) begin
          state <= IDLE;
          busy  <= 1'b0;
          presc <= '0;
        end
      end else if (cfg_valid) begin
        tgt   <= cfg_target;
        stp   <= cfg_step_eff;
        div   <= cfg_div;
        presc <= '0;
`ifdef PWM_FADE_BREATHE_EN
        breathe <= cfg_breathe;
        dest    <= cfg_target;
`endif
        if (cfg_target > duty_out) begin
          state <= UP;
          busy  <= 1'b1;
        end else if (cfg_target < duty_out) begin
          state <= DOWN;
          busy  <= 1'b1;
        end else if (cfg_loop) begin
          // The target is already reached, so start the looping ramp on its way down to 0.
          state <= DOWN;
          busy  <= 1'b1;
`ifdef PWM_FADE_BREATHE_EN
          dest  <= '0;
`endif
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (tick) begin
          presc <= '0;
          if ((state == UP) ? up_hit : dn_hit) begin
            duty_out <= goal;
            if (loop_on) begin
              // Reverse direction at each end of the breathe loop.
              if (goal == '0) begin
                state <= UP;
`ifdef PWM_FADE_BREATHE_EN
                dest  <= tgt;
`endif
              end else begin
                state <= DOWN;
`ifdef PWM_FADE_BREATHE_EN
                dest  <= '0;
`endif
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (state == UP) begin
            duty_out <= up_sum[DUTY_W-1:0];
          end else begin
            duty_out <= duty_out - stp_ext;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule
